// File: rtl/servo_pwm_multicanal.sv
// rtl/servo_pwm_multicanal.sv - multi-channel servo PWM generator with per-period width ramping
module servo_pwm_multicanal #(
    parameter int NUM_CANAIS    = 4,
    parameter int CONF_PERIODO  = 1000000,
    parameter int SEL_W         = 3,
    parameter int LARGURA_BASE  = 50000,
    parameter int LARGURA_DELTA = 10000,
    parameter int PASSO_RAMPA   = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CANAIS*SEL_W-1:0] posicao,
    input  logic [NUM_CANAIS-1:0]       habilita,
    output logic [NUM_CANAIS-1:0]       pwm,
    output logic [NUM_CANAIS-1:0]       pronto,
    output logic                        fim_periodo
);

    localparam logic [31:0] ULTIMA = 32'(CONF_PERIODO - 1);
    localparam logic [31:0] BASE   = 32'(LARGURA_BASE);
    localparam logic [31:0] DELTA  = 32'(LARGURA_DELTA);
    localparam logic [31:0] PASSO  = 32'(PASSO_RAMPA);

    logic [31:0]           contagem;
    logic                  fronteira;
    logic [NUM_CANAIS-1:0] hab_reg;
    logic [31:0]           largura      [NUM_CANAIS];
    logic [31:0]           alvo         [NUM_CANAIS];
    logic [31:0]           largura_prox [NUM_CANAIS];
    logic [31:0]           alvo_prox    [NUM_CANAIS];

    // Last cycle of the period: the only cycle where inputs are taken and widths move
    assign fronteira = (contagem == ULTIMA);

    // Shared period counter and the one-cycle period-start pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            contagem    <= '0;
            fim_periodo <= 1'b0;
        end else begin
            contagem    <= fronteira ? 32'd0 : contagem + 32'd1;
            fim_periodo <= fronteira;
        end
    end

    // New target and ramp step per channel; the ramp starts from the present width,
    // so a target change mid-ramp just redirects it and the clamp prevents overshoot
    always_comb begin
        for (int i = 0; i < NUM_CANAIS; i++) begin
            alvo_prox[i]    = alvo[i];
            largura_prox[i] = largura[i];
            if (fronteira) begin
                alvo_prox[i] = BASE + 32'(posicao[i*SEL_W +: SEL_W]) * DELTA;
                if (PASSO == 32'd0) begin
                    largura_prox[i] = alvo_prox[i];
                end else if (alvo_prox[i] > largura[i]) begin
                    largura_prox[i] = (alvo_prox[i] - largura[i] > PASSO) ?
                                      largura[i] + PASSO : alvo_prox[i];
                end else begin
                    largura_prox[i] = (largura[i] - alvo_prox[i] > PASSO) ?
                                      largura[i] - PASSO : alvo_prox[i];
                end
            end
        end
    end

    // Per-channel state and registered outputs; pwm compares against the current width
    always_ff @(posedge clock) begin
        if (!reset) begin
            hab_reg <= '0;
            pwm     <= '0;
            pronto  <= '1;
            for (int i = 0; i < NUM_CANAIS; i++) begin
                largura[i] <= BASE;
                alvo[i]    <= BASE;
            end
        end else begin
            if (fronteira) begin
                hab_reg <= habilita;
            end
            for (int i = 0; i < NUM_CANAIS; i++) begin
                largura[i] <= largura_prox[i];
                alvo[i]    <= alvo_prox[i];
                pwm[i]     <= hab_reg[i] & (contagem < largura[i]);
                pronto[i]  <= (largura_prox[i] == alvo_prox[i]);
            end
        end
    end

endmodule
